// File: rtl/pe_vec_mac.sv
// pe_vec_mac: vector multiply-accumulate processing element.
//
// Each accepted beat carries LANES pixel/weight pairs. The pairs are
// multiplied lane by lane, the lane products are summed, and the sum is
// added into a running window accumulator. A beat flagged in_last closes
// the window: the window sum is presented on out_data/out_valid, and the
// next beat starts a new window. The pixels of each accepted beat are
// forwarded unchanged on pix_out for the neighbouring PE.
//
// Pipeline: S1 operand registers (which also drive pix_out), S2 per-lane
// shift-add products, S3 lane sum plus accumulate plus result register.
// While a result is held (out_valid=1, out_ready=0) the whole pipeline
// freezes and in_ready drops.
//
// Optional feature: define PE_VEC_MAC_SATURATE_EN to clamp the accumulator
// to the representable range (signed or unsigned, following the current
// beat). The clamp is sticky until the end of the window and is flagged
// on out_sat. Without the macro the accumulator wraps and out_sat stays 0.
//
// Ports:
//   clk, rstn              clock (rising edge), synchronous active-low reset
//   in_valid/in_ready      input beat handshake
//   in_pix, in_wgt         packed lane operands, lane 0 in the LSBs
//   in_last                beat closes the current accumulation window
//   in_signed              beat operands are two's complement
//   pix_out, pix_out_valid pixels of the latest accepted beat, 1-cycle pulse
//   out_valid/out_ready    result handshake
//   out_data, out_sat      window dot product and its clamp flag
module pe_vec_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_pix,
  input  logic [LANES*WEIGHT_WIDTH-1:0] in_wgt,
  input  logic                          in_last,
  input  logic                          in_signed,
  output logic [LANES*DATA_WIDTH-1:0]   pix_out,
  output logic                          pix_out_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic                          out_sat
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  // Exact product by shift-add. Both operands are extended to the full
  // product width first, so the modulo-2^PW sum of partial products is the
  // exact signed or unsigned product.
  function automatic logic [PW-1:0] lane_mul(input logic [DATA_WIDTH-1:0]   a,
                                             input logic [WEIGHT_WIDTH-1:0] b,
                                             input logic                    sgn);
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] acc;
    a_ext = sgn ? PW'(signed'(a)) : PW'(a);
    b_ext = sgn ? PW'(signed'(b)) : PW'(b);
    acc   = '0;
    for (int i = 0; i < PW; i++) begin
      acc = acc + (b_ext[i] ? (a_ext << i) : '0);
    end
    return acc;
  endfunction

  // Extend a lane product to accumulator width following the beat's signedness.
  function automatic logic [ACC_WIDTH-1:0] prod_ext(input logic [PW-1:0] p,
                                                    input logic          sgn);
    if (sgn) begin
      return ACC_WIDTH'(signed'(p));
    end else begin
      return ACC_WIDTH'(p);
    end
  endfunction

  logic                    stall_s;
  logic                    accept_s;

  logic                    s1_valid_r;
  logic [LANES*WEIGHT_WIDTH-1:0] s1_wgt_r;
  logic                    s1_last_r;
  logic                    s1_signed_r;

  logic [PW-1:0]           mul_s [LANES];

  logic                    s2_valid_r;
  logic                    s2_last_r;
  logic                    s2_signed_r;
  logic [PW-1:0]           s2_prod_r [LANES];

  logic [ACC_WIDTH-1:0]    lane_sum_s;
  logic [ACC_WIDTH-1:0]    base_s;
  logic [ACC_WIDTH-1:0]    acc_next_s;
  logic                    sat_next_s;
  logic [ACC_WIDTH-1:0]    acc_r;
  logic                    start_r;   // next S3 beat opens a new window

  // A held result freezes every stage; reset also blocks acceptance.
  assign stall_s  = out_valid && !out_ready;
  assign in_ready = rstn && !stall_s;
  assign accept_s = in_valid && in_ready;

  // S1: capture operands of accepted beats; the pixel register is pix_out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r    <= 1'b0;
      pix_out       <= '0;
      s1_wgt_r      <= '0;
      s1_last_r     <= 1'b0;
      s1_signed_r   <= 1'b0;
      pix_out_valid <= 1'b0;
    end else begin
      pix_out_valid <= accept_s;
      if (!stall_s) begin
        s1_valid_r <= accept_s;
      end
      if (accept_s) begin
        pix_out     <= in_pix;
        s1_wgt_r    <= in_wgt;
        s1_last_r   <= in_last;
        s1_signed_r <= in_signed;
      end
    end
  end

  // Per-lane products of the operands held in S1.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      mul_s[l] = lane_mul(pix_out[l*DATA_WIDTH +: DATA_WIDTH],
                          s1_wgt_r[l*WEIGHT_WIDTH +: WEIGHT_WIDTH],
                          s1_signed_r);
    end
  end

  // S2: register the lane products.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_r  <= 1'b0;
      s2_last_r   <= 1'b0;
      s2_signed_r <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        s2_prod_r[l] <= '0;
      end
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_last_r   <= s1_last_r;
        s2_signed_r <= s1_signed_r;
        for (int l = 0; l < LANES; l++) begin
          s2_prod_r[l] <= mul_s[l];
        end
      end
    end
  end

  // Lane sum and the value the window restarts from or continues.
  always_comb begin
    lane_sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_s = lane_sum_s + prod_ext(s2_prod_r[l], s2_signed_r);
    end
    base_s = start_r ? '0 : acc_r;
  end

`ifdef PE_VEC_MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};

  logic                 sat_r;
  logic                 sticky_s;
  logic [ACC_WIDTH:0]   wide_s;
  logic                 ovf_s;

  // Saturating add: one guard bit detects overflow; once clamped the
  // accumulator holds its clamp value until the window closes.
  always_comb begin
    sticky_s = start_r ? 1'b0 : sat_r;
    if (s2_signed_r) begin
      wide_s = {base_s[ACC_WIDTH-1], base_s} + {lane_sum_s[ACC_WIDTH-1], lane_sum_s};
      ovf_s  = wide_s[ACC_WIDTH] ^ wide_s[ACC_WIDTH-1];
    end else begin
      wide_s = {1'b0, base_s} + {1'b0, lane_sum_s};
      ovf_s  = wide_s[ACC_WIDTH];
    end
    if (sticky_s) begin
      acc_next_s = acc_r;
      sat_next_s = 1'b1;
    end else if (ovf_s) begin
      if (s2_signed_r) begin
        acc_next_s = wide_s[ACC_WIDTH] ? SMIN : SMAX;
      end else begin
        acc_next_s = UMAX;
      end
      sat_next_s = 1'b1;
    end else begin
      acc_next_s = wide_s[ACC_WIDTH-1:0];
      sat_next_s = 1'b0;
    end
  end

  // Sticky clamp flag for the current window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sat_r <= 1'b0;
    end else if (!stall_s && s2_valid_r) begin
      sat_r <= sat_next_s;
    end
  end
`else
  // Plain modulo-2^ACC_WIDTH accumulation.
  always_comb begin
    acc_next_s = base_s + lane_sum_s;
    sat_next_s = 1'b0;
  end
`endif

  // S3: accumulate and present the window result. A closing beat arriving
  // while the previous result is being taken simply overwrites it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_r     <= '0;
      start_r   <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall_s) begin
      if (s2_valid_r) begin
        acc_r   <= acc_next_s;
        start_r <= s2_last_r;
      end
      if (s2_valid_r && s2_last_r) begin
        out_valid <= 1'b1;
        out_data  <= acc_next_s;
        out_sat   <= sat_next_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_vec_mac.sv
module tb_pe_vec_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        in_valid, in_ready, in_last, in_signed;
  logic [31:0] in_pix, in_wgt, pix_out;
  logic        pix_out_valid, out_valid, out_ready, out_sat;
  logic [23:0] out_data;

  logic        w_in_valid, w_in_ready, w_in_last, w_in_signed;
  logic [31:0] w_in_pix, w_in_wgt, w_pix_out;
  logic        w_pix_out_valid, w_out_valid, w_out_ready, w_out_sat;
  logic [15:0] w_out_data;

  pe_vec_mac u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_wgt(in_wgt), .in_last(in_last), .in_signed(in_signed),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  pe_vec_mac #(.ACC_WIDTH(16)) u_w16 (
    .clk(clk), .rstn(rstn), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_pix(w_in_pix), .in_wgt(w_in_wgt), .in_last(w_in_last), .in_signed(w_in_signed),
    .pix_out(w_pix_out), .pix_out_valid(w_pix_out_valid), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_data(w_out_data), .out_sat(w_out_sat)
  );

  typedef struct {
    logic [31:0] pix;
    logic [31:0] wgt;
    logic        last;
    logic        sgn;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        sat;
  } res_t;

  vec_t  vecs [10];
  res_t  sb_q [$];
  res_t  mon_r;
  int    errors = 0;
  int    checks = 0;
  int    hs_count = 0;
  logic  stall_prev = 1'b0;
  logic [23:0] data_prev = 24'd0;
  logic  rnd_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference lane dot product of one beat, in plain integer arithmetic.
  function automatic longint beat_sum(input logic [31:0] p, input logic [31:0] w, input logic s);
    longint t;
    int a, b;
    t = 0;
    for (int l = 0; l < 4; l++) begin
      a = s ? int'($signed(p[l*8 +: 8])) : int'(p[l*8 +: 8]);
      b = s ? int'($signed(w[l*8 +: 8])) : int'(w[l*8 +: 8]);
      t = t + longint'(a * b);
    end
    return t;
  endfunction

  // Present one beat from posedge+1, wait for acceptance, queue its result.
  task automatic drive_beat(input logic [31:0] pix, input logic [31:0] wgt, input logic last,
                            input logic sgn, input logic [23:0] exp_d, output int tries);
    logic ok;
    in_pix = pix; in_wgt = wgt; in_last = last; in_signed = sgn; in_valid = 1'b1;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept", {63'd0, ok}, 64'd1);
    if (ok && last) sb_q.push_back('{data: exp_d, sat: 1'b0});
  endtask

  // Scoreboard and hold-while-stalled monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h with no result pending", out_data);
      end else begin
        mon_r = sb_q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_r.data));
        chk("out_sat", 64'(out_sat), 64'(mon_r.sat));
      end
    end
    if (stall_prev) begin
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_data", 64'(out_data), 64'(data_prev));
    end
    stall_prev = rstn && out_valid && !out_ready;
    data_prev  = out_data;
  end

  initial begin
    int   tr;
    longint m_acc;
    logic [31:0] rp, rw;
    logic rs, rl;
    int   run_len;
    int   hs0;

    vecs[0] = '{32'h04030201, 32'h08070605, 1'b1, 1'b0, 24'd70};
    vecs[1] = '{32'h000000FD, 32'h00000007, 1'b1, 1'b1, 24'hFFFFEB};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 24'd0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 24'd0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 24'd780300};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 24'd4};
    vecs[6] = '{32'h80808080, 32'h7F7F7F7F, 1'b1, 1'b1, 24'hFF0200};
    vecs[7] = '{32'h000000FF, 32'h00000002, 1'b0, 1'b0, 24'd0};
    vecs[8] = '{32'h000000FF, 32'h00000002, 1'b1, 1'b1, 24'd508};
    vecs[9] = '{32'h80808080, 32'h80808080, 1'b1, 1'b1, 24'h010000};

    rstn = 1'b0; in_valid = 1'b0; in_pix = '0; in_wgt = '0; in_last = 1'b0; in_signed = 1'b0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_pix = '0; w_in_wgt = '0; w_in_last = 1'b0; w_in_signed = 1'b0;
    w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pix_out_valid", 64'(pix_out_valid), 64'd0);
    chk("rst_pix_out", 64'(pix_out), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single beat: forwarding after 1 cycle, result after 3.
    drive_beat(32'h04030201, 32'h08070605, 1'b1, 1'b0, 24'd70, tr);
    chk("pix_out", 64'(pix_out), 64'h04030201);
    chk("pix_out_valid", 64'(pix_out_valid), 64'd1);
    @(negedge clk); chk("lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_c2", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_c3", 64'(out_valid), 64'd1);
    chk("pix_out_valid_pulse", 64'(pix_out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Table of beats, with bubbles inserted (one falls inside a window).
    for (int i = 0; i < 10; i++) begin
      drive_beat(vecs[i].pix, vecs[i].wgt, vecs[i].last, vecs[i].sgn, vecs[i].exp, tr);
      if (i % 3 == 2) begin
        @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    #1;

    // Back-to-back single-beat windows at full rate.
    hs0 = hs_count;
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'(i + 1), 32'd3, 1'b1, 1'b0, 24'(3 * (i + 1)), tr);
      chk("throughput_tries", 64'(tr), 64'd1);
    end
    repeat (4) @(negedge clk);
    chk("throughput_results", 64'(hs_count - hs0), 64'd4);
    @(posedge clk);
    #1;

    // Backpressure: result held 5 cycles while beats keep coming.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          drive_beat(32'(i + 1), 32'd10, 1'b1, 1'b0, 24'(10 * (i + 1)), tr);
        end
      end
      begin
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("stall_seen", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    #1;

    // Reset in the middle of a 4-beat window discards it.
    drive_beat(32'h11111111, 32'h22222222, 1'b0, 1'b0, 24'd0, tr);
    drive_beat(32'h33333333, 32'h44444444, 1'b0, 1'b0, 24'd0, tr);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rstn = 1'b1;
    drive_beat(32'h00000002, 32'h00000009, 1'b1, 1'b0, 24'd18, tr);
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    #1;

    // Random windows against the integer model, random backpressure.
    m_acc = 0;
    run_len = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          rp = $urandom; rw = $urandom; rs = 1'($urandom_range(0, 1));
          rl = (i == 29) || (run_len == 5) || ($urandom_range(0, 2) == 0);
          m_acc = m_acc + beat_sum(rp, rw, rs);
          drive_beat(rp, rw, rl, rs, 24'(m_acc), tr);
          if (rl) begin
            m_acc = 0;
            run_len = 0;
          end else begin
            run_len++;
          end
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    // 16-bit accumulator: 2 x 65025 overflows.
    w_in_pix = 32'h000000FF; w_in_wgt = 32'h000000FF; w_in_signed = 1'b0;
    w_in_last = 1'b0; w_in_valid = 1'b1;
    @(negedge clk); chk("w16_ready0", 64'(w_in_ready), 64'd1);
    @(posedge clk); #1;
    w_in_last = 1'b1;
    @(negedge clk); chk("w16_ready1", 64'(w_in_ready), 64'd1);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    for (int k = 0; k < 10 && !w_out_valid; k++) @(negedge clk);
    chk("w16_out_valid", 64'(w_out_valid), 64'd1);
`ifdef PE_VEC_MAC_SATURATE_EN
    chk("w16_out_data", 64'(w_out_data), 64'd65535);
    chk("w16_out_sat", 64'(w_out_sat), 64'd1);
`else
    chk("w16_out_data", 64'(w_out_data), 64'd64514);
    chk("w16_out_sat", 64'(w_out_sat), 64'd0);
`endif

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_vec_mac.md
PE_VEC_MAC -- requirements
Module: pe_vec_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width per lane.
REQ-002 Parameter WEIGHT_WIDTH, default 8: weight width per lane.
REQ-003 Parameter LANES, default 4: number of parallel pixel/weight pairs per beat, at least 1.
REQ-004 Parameter ACC_WIDTH, default 24: accumulator and result width, at least DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  beat present on in_pix/in_wgt.
REQ-008 in_ready  output  1  beat accepted when in_valid and in_ready both high.
REQ-009 in_pix  input  LANES*DATA_WIDTH  packed pixels, lane 0 in LSBs.
REQ-010 in_wgt  input  LANES*WEIGHT_WIDTH  packed weights, lane 0 in LSBs.
REQ-011 in_last  input  1  final beat of current accumulation window.
REQ-012 in_signed  input  1  beat operands are two's complement when 1, unsigned when 0.
REQ-013 pix_out  output  LANES*DATA_WIDTH  pixels of most recent accepted beat, forwarded to the next PE.
REQ-014 pix_out_valid  output  1  pulses 1 cycle after each accepted beat.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_data  output  ACC_WIDTH  accumulated dot product of the window.
REQ-018 out_sat  output  1  result was clamped; see Configuration.

Function
REQ-019 Pipeline SHALL be 3 stages: S1 registers operands; S2 computes per-lane products by shift-add of partial products; S3 sums the lanes and adds the sum into the accumulator.
REQ-020 Per-lane product SHALL be exact at DATA_WIDTH+WEIGHT_WIDTH bits; it is sign- or zero-extended to ACC_WIDTH according to that beat's in_signed.
REQ-021 The accumulator SHALL restart from the lane sum on the first beat after a beat with in_last; all other beats add to the running value.
REQ-022 out_valid SHALL rise 3 cycles after acceptance of an in_last beat when there is no stall; out_data is the full window sum.
REQ-023 A single-beat window (in_last on every beat) SHALL produce one result per beat at full throughput.
REQ-024 out_valid and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Stall is out_valid=1 and out_ready=0; during a stall the whole pipeline SHALL freeze and in_ready SHALL be 0.
REQ-026 When out_valid, out_ready, and a new in_last result arriving at S3 occur together, the new result SHALL replace the old one with no bubble and no loss.
REQ-027 Bubbles (in_valid=0) SHALL NOT alter the accumulator or advance the window.
REQ-028 pix_out SHALL update only on accepted beats; it is independent of out_ready except through in_ready.
REQ-029 Without saturation, accumulator overflow SHALL wrap modulo 2^ACC_WIDTH.

Reset
REQ-030 On rstn=0 at a clock edge: out_valid=0, pix_out_valid=0, pix_out=0, out_data=0, out_sat=0, accumulator=0, all stage valids=0, and the next beat starts a new window.
REQ-031 in_ready SHALL be 0 while rstn=0 and 1 in the first cycle after release.
REQ-032 Reset in mid-window SHALL discard partial sums and in-flight beats; no out_valid is produced for them.

Configuration
REQ-033 Macro PE_VEC_MAC_SATURATE_EN defined: the accumulator SHALL clamp to max/min representable value (signed range if the window's current beat is signed, else unsigned) and out_sat=1 with that result; clamp is sticky to end of window.
REQ-034 Macro PE_VEC_MAC_SATURATE_EN undefined: wrap per REQ-029, out_sat tied to 0.

Verification
REQ-035 Defaults, unsigned, one beat pix={1,2,3,4} wgt={5,6,7,8} last=1 -> out_data=70 after 3 cycles, pix_out={1,2,3,4} after 1 cycle.
REQ-036 Signed, pix lane0=-3 (0xFD), wgt lane0=7, other lanes 0, last=1 -> out_data=-21 (0xFFFFEB).
REQ-037 3-beat window, each beat pix all 255, wgt all 255, unsigned -> single out_data=780300, out_valid only after beat 3.
REQ-038 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data unchanged, no beat lost; after out_ready=1 stream resumes in order.
REQ-039 ACC_WIDTH=16, unsigned window of 2 beats summing 130050 -> wraps to 64514 with out_sat=0 (macro off); 65535 with out_sat=1 (macro on).
REQ-040 rstn=0 after beat 2 of a 4-beat window -> no result; next 1-beat window gives the correct standalone sum.
